// File: rtl/fpu_div.sv
// Multicycle half/single precision floating-point divider.
// Restoring mantissa division, one quotient bit per cycle, start/done handshake.
module fpu_div (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        floatType,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] Result,
    output logic [3:0]  FPUFlags
);

    localparam int unsigned MW = 24;  // mantissa incl. hidden bit (single)
    localparam int unsigned RW = 25;  // remainder: < 2*mB
    localparam int unsigned QW = 25;  // quotient: < 2^(W+2)
    localparam int unsigned EW = 10;  // signed working exponent
    localparam int unsigned CW = 5;   // iteration counter

    typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;

    state_t state, state_n;

    logic          sa, sb, sp_sign;
    logic [7:0]    ea, eb, sp_exp;
    logic [MW-1:0] ma, mb;
    logic [EW-1:0] bias;
    logic          accept, a_zero, b_zero, special;
    logic [31:0]   sp_res;
    logic [3:0]    sp_flags;

    logic          sign_q, ft_q;
    logic [MW-1:0] mb_q;
    logic [RW-1:0] rem_q, rem_diff, rem_n;
    logic [QW-1:0] q_q;
    logic [EW-1:0] exp_q;
    logic [CW-1:0] cnt_q;
    logic          ge;

    logic          hi;
    logic [22:0]   frac;
    logic [EW-1:0] exp_n, emax;
    logic [31:0]   norm_res;
    logic [3:0]    norm_flags;

    // Operand field extraction for the selected format
    always_comb begin
        sa   = A[15];
        sb   = B[15];
        ea   = {3'b0, A[14:10]};
        eb   = {3'b0, B[14:10]};
        ma   = {13'b0, 1'b1, A[9:0]};
        mb   = {13'b0, 1'b1, B[9:0]};
        bias = EW'(15);
        if (floatType) begin
            sa   = A[31];
            sb   = B[31];
            ea   = A[30:23];
            eb   = B[30:23];
            ma   = {1'b1, A[22:0]};
            mb   = {1'b1, B[22:0]};
            bias = EW'(127);
        end
    end

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign a_zero   = (ea == 8'h00);
    assign b_zero   = (eb == 8'h00);
    assign special  = a_zero || b_zero;
    assign sp_sign  = sa ^ sb;
    assign sp_exp   = b_zero ? 8'hFF : 8'h00;
    assign sp_res   = floatType ? {sp_sign, sp_exp, 23'b0}
                                : {16'b0, sp_sign, sp_exp[4:0], 10'b0};
    // Divide-by-zero wins over zero dividend
    assign sp_flags = {sp_sign, ~b_zero, 1'b0, b_zero};

    // One restoring-division step
    always_comb begin
        ge       = (rem_q >= RW'(mb_q));
        rem_diff = ge ? (rem_q - RW'(mb_q)) : rem_q;
        rem_n    = {rem_diff[RW-2:0], 1'b0};
    end

    // Normalisation, truncation and exponent range handling
    always_comb begin
        hi         = ft_q ? q_q[24] : q_q[11];
        frac       = ft_q ? (hi ? q_q[23:1] : q_q[22:0])
                          : {13'b0, (hi ? q_q[10:1] : q_q[9:0])};
        exp_n      = hi ? exp_q : (exp_q - EW'(1));
        emax       = ft_q ? EW'(255) : EW'(31);
        norm_res   = ft_q ? {sign_q, exp_n[7:0], frac}
                          : {16'b0, sign_q, exp_n[4:0], frac[9:0]};
        norm_flags = {sign_q, 3'b000};
        if ($signed(exp_n) <= $signed(EW'(0))) begin
            norm_res   = ft_q ? {sign_q, 31'b0} : {16'b0, sign_q, 15'b0};
            norm_flags = {sign_q, 3'b100};
        end else if ($signed(exp_n) >= $signed(emax)) begin
            norm_res   = ft_q ? {sign_q, 8'hFF, 23'b0} : {16'b0, sign_q, 5'h1F, 10'b0};
            norm_flags = {sign_q, 3'b001};
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (accept) state_n = special ? DONE : DIVIDE;
                else        state_n = IDLE;
            end
            DIVIDE:     if (cnt_q == CW'(0)) state_n = NORM;
            NORM:       state_n = DONE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= (state_n == DIVIDE) || (state_n == NORM);
            done  <= (state_n == DONE);
        end
    end

    // Operand latches, division datapath and result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q   <= 1'b0;
            ft_q     <= 1'b0;
            mb_q     <= '0;
            rem_q    <= '0;
            q_q      <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            Result   <= '0;
            FPUFlags <= '0;
        end else if (accept) begin
            sign_q <= sp_sign;
            ft_q   <= floatType;
            mb_q   <= mb;
            rem_q  <= RW'(ma);
            q_q    <= '0;
            exp_q  <= EW'(ea) - EW'(eb) + bias;
            cnt_q  <= floatType ? CW'(24) : CW'(11);
            if (special) begin
                Result   <= sp_res;
                FPUFlags <= sp_flags;
            end
        end else if (state == DIVIDE) begin
            rem_q <= rem_n;
            q_q   <= {q_q[QW-2:0], ge};
            cnt_q <= cnt_q - CW'(1);
        end else if (state == NORM) begin
            Result   <= norm_res;
            FPUFlags <= norm_flags;
        end
    end

endmodule

// File: doc/fpu_div.md
# fpu_div

Multicycle floating-point divider for the datapath FPU slice, in half (16-bit) and single (32-bit) precision. It completes the FPU: the combinational unit handles ADD/MUL, and this block computes Result = A / B by restoring mantissa division, one quotient bit per cycle. It is driven by a start/done handshake so the controller can stall while the divide is in progress. Operand formats, flag ordering and truncation rules match the existing FPU.

## Interface
- Parameters: none. Widths are selected at run time by floatType.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request a divide; sampled only when the block can accept
- floatType  input  1  0 = half (A[15:0], B[15:0]); 1 = single (A, B)
- A  input  32  dividend
- B  input  32  divisor
- busy  output  1  high in DIVIDE and NORM
- done  output  1  one-cycle pulse; Result and FPUFlags valid
- Result  output  32  quotient; half results zero-extended (bits 31:16 = 0)
- FPUFlags  output  4  {Negative, Zero, Carry, Overflow}

## Operation
- Formats:
  - Half: sign [15], exponent [14:10], fraction [9:0], bias 15, W = 10.
  - Single: sign [31], exponent [30:23], fraction [22:0], bias 127, W = 23.
  - Implicit leading 1. An operand with exponent 0 is treated as zero. No NaN/denormal inputs are supported.
- Sign: sA ^ sB in every case, including the special cases.
- States: IDLE, DIVIDE, NORM, DONE.
  - Start is accepted in IDLE or DONE. Start in DIVIDE or NORM is ignored.
- Accept edge:
  - Latch sign, floatType and mantissas mA = {1,fracA}, mB = {1,fracB}.
  - Latch expDiff = eA − eB + bias as a 10-bit signed value.
- Special cases (checked at the accept edge, in priority order; they skip DIVIDE and go straight to DONE with Result written):
  1. B zero → infinity: sign, exponent all ones, fraction 0. Overflow = 1.
  2. A zero → signed zero. Zero = 1.
- DIVIDE, restoring division:
  - Remainder starts at mA, divisor is mB.
  - Each cycle: if rem ≥ mB, the quotient bit is 1 and rem −= mB; otherwise the bit is 0. Then rem <<= 1.
  - N = W+2 iterations (12 for half, 25 for single).
  - This yields q = floor(mA·2^(W+1) / mB), with q in [2^W, 2^(W+2)).
- NORM (one cycle):
  - If q[W+1] = 1: fraction = q[W:1], exponent = expDiff.
  - Otherwise: fraction = q[W−1:0], exponent = expDiff − 1.
  - Truncate; no rounding.
  - Exponent ≤ 0 → signed zero, Zero = 1.
  - Exponent ≥ all ones → infinity, Overflow = 1.
- Flags:
  - Negative = Result sign bit for the format.
  - Zero = magnitude bits all zero.
  - Carry = 0 always.
  - Overflow as defined above.
- Result and FPUFlags hold until the next Result write. They are updated only at the NORM edge or the special-case accept edge.

## Timing
- Reset (asynchronous, any time): state = IDLE, busy = 0, done = 0, Result = 0, FPUFlags = 0.
- Reset during DIVIDE or NORM aborts the operation; no done pulse follows.
- Normal divide:
  - Accept at edge k.
  - DIVIDE on edges k+1 … k+N; NORM edge is k+N+1.
  - done is high during the cycle after edge k+N+1: latency N+2 edges (14 half, 27 single).
- Special case: done is high during the cycle after the accept edge (latency 1).
- busy is high from after the accept edge until the NORM edge. busy = 0 while done = 1.
- DONE lasts exactly one cycle, then returns to IDLE.
- Start asserted during DONE is accepted on that edge, allowing back-to-back divides with no idle bubble.
- Operands may change after the accept edge; the block works only from its latched copies.

## Test plan
- Single, A=0x40C00000 (6.0), B=0x40000000 (2.0) → Result=0x40400000, FPUFlags=0000, done 27 edges after accept.
- Half, A=0x3C00 (1.0), B=0x4200 (3.0) → Result=0x00003555 (truncated 1/3), flags 0000, done after 14 edges, busy high for 13 cycles.
- Single, A=0xBFC00000 (−1.5), B=0x3F000000 (0.5) → Result=0xC0400000, Negative=1.
- Single, A=0x3F800000, B=0x00000000 → Result=0x7F800000, Overflow=1, done 1 edge after accept. Then A=0, B=0x3F800000 → Result=0x00000000, Zero=1.
- Single, A=0x00800000, B=0x7F000000 → exponent underflow, Result=0x00000000, Zero=1.
- Sequencing:
  - Pulse start again at edge k+5 of a running divide → ignored; the first result is unaffected.
  - Assert reset at edge k+5 of another divide → all outputs 0 and no done pulse.
  - Start held high through done → the second divide is accepted on the DONE edge.
